aes_ctr_engine: RTL and testbench
=================================

Name: aes_ctr_engine

Overview:
- AES-128 counter-mode (CTR) stream engine built around the team's multicycle aes_128 core, which is instantiated inside this block.
- Accepts a key and an initial counter block (IV), then encrypts a stream of 128-bit data blocks. Each output is data XOR AES(key, counter); the counter's low CTR_WIDTH bits increment per block.
- Handshaked valid/ready streams on both sides. A parametrised output FIFO decouples the core from output backpressure.

Parameters:
- CTR_WIDTH, 32, number of low IV bits that form the incrementing counter (8..128); bits 127:CTR_WIDTH are a fixed nonce.
- OUT_DEPTH, 4, output FIFO depth in blocks (power of two, >=2).
- CORE_LATENCY, 10, cycles from core input sample to core valid; one block in flight in the core at a time.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  pulse: latch cfg_key/cfg_iv and open a stream (honoured in IDLE only)
- cfg_key  in  128  AES key
- cfg_iv  in  128  initial counter block
- s_valid  in  1  input block valid
- s_ready  out  1  engine accepts input block
- s_data  in  128  plaintext/ciphertext block
- s_last  in  1  final block of stream
- m_valid  out  1  output block valid
- m_ready  in  1  downstream accepts output
- m_data  out  128  s_data XOR keystream
- m_last  out  1  final block of stream
- busy  out  1  state != IDLE
- ctr_wrap  out  1  sticky: counter overflowed; stream truncated

Behaviour:
- Reset: clk and rst_n as stated; reset is asynchronous and active-low. Reset drives state to IDLE, empties FIFO and in-flight tracking, and clears the counter and key registers.
- Output reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, ctr_wrap=0.
- Reset mid-stream discards all in-flight and buffered blocks.
- State IDLE:
  - s_ready=0.
  - cfg_start=1 latches key and IV into ctr, clears ctr_wrap, and moves to RUN next cycle.
- State RUN:
  - s_ready=1 iff the core has no block in flight and (FIFO occupancy + in-flight) < OUT_DEPTH.
  - On s_valid&&s_ready:
    - Hold s_data and s_last in the hold register.
    - Present ctr to the core with the latched key.
    - Update ctr[CTR_WIDTH-1:0] to +1 modulo 2^CTR_WIDTH; upper bits are unchanged.
  - When the core asserts valid: push hold XOR core out_bus and hold_last into the FIFO; the in-flight flag clears the same cycle.
  - Throughput: one block per CORE_LATENCY+1 cycles when m_ready stays high.
  - Accepted s_last=1 -> DRAIN.
  - Counter overflow: an accept where ctr[CTR_WIDTH-1:0] is all-ones sets ctr_wrap=1 and goes to DRAIN. That block is forced m_last=1. The wrapped counter value is never issued.
  - cfg_start is ignored.
- State DRAIN:
  - s_ready=0.
  - Finish the in-flight block and drain the FIFO.
  - Transaction m_valid&&m_ready&&m_last -> IDLE next cycle.
  - cfg_start is ignored.
- Output side:
  - m_valid = FIFO not empty; m_data and m_last come from the FIFO head.
  - m_data and m_last must be held stable while m_valid&&!m_ready.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A full FIFO never overflows; the credit rule on s_ready guarantees this.
- Key and counter registers stay stable to the core while busy; cfg_key and cfg_iv changes after cfg_start have no effect.
- Simultaneous core valid and accept cannot occur, because s_ready requires no block in flight. A new accept is allowed the cycle after the core valid.

Test Plan:
- NIST SP800-38A CTR, key 2b7e151628aed2a6abf7158809cf4f3c, IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff:
  - Send 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51 (s_last=1).
  - Required: m_data = 874d6191b620e3261bef6864990db6ce then 9806f66b7970fdff8617187bb9fffdff, with m_last=1 on the second.
  - Then busy=0.
- Backpressure: same vectors with m_ready=0 for 40 cycles.
  - Required: m_valid=1 with the first result held stable, and s_ready never 1 once occupancy + in-flight = OUT_DEPTH.
  - After m_ready=1: identical output order and values.
- Counter wrap, CTR_WIDTH=32, IV=00000000000000000000000000000000_ffffffff... (low 32 bits ffffffff):
  - Send 3 blocks.
  - Required: one output with m_last=1, ctr_wrap=1, s_ready=0 after the first accept, return to IDLE.
  - The next cfg_start clears ctr_wrap.
- cfg_start pulsed in RUN with a different key mid-stream -> outputs still match the original key's NIST results.
- rst_n asserted while a block is in the core -> all outputs read their reset values immediately (async). After release and a new cfg_start, the NIST vector passes.
- Throughput: 8 back-to-back blocks, m_ready=1 -> accepts spaced exactly CORE_LATENCY+1 cycles apart, with the counter incrementing by 1 per block.

Source files
------------

// File: rtl/aes_ctr_engine.sv
// aes_ctr_engine: AES-128 counter-mode stream engine.
//
// Purpose: latches a key and an initial counter block, then encrypts a stream of
// 128-bit blocks as data XOR AES(key, counter). The low CTR_WIDTH bits of the
// counter increment per block; the upper bits are a fixed nonce. One block is in
// the AES core at a time, and an output FIFO absorbs downstream backpressure.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_cfg_start, i_cfg_key, i_cfg_iv   open a stream (honoured in IDLE only)
//   i_s_valid/o_s_ready/i_s_data/i_s_last   input block stream
//   o_m_valid/i_m_ready/o_m_data/o_m_last   output block stream
//   o_busy                          engine not idle
//   o_ctr_wrap                      sticky: counter overflowed, stream truncated
//
// Also contains aes_128_core, the multicycle AES-128 encryptor used inside.

// aes_128_core: one block at a time. On i_start (while idle) the block and key are
// sampled; o_valid rises LATENCY cycles later (counting the sample cycle) and stays
// for one cycle. Rounds 1..9 run one per cycle with on-the-fly key expansion; the
// final round is combinational on the output so the next block can be started the
// cycle after o_valid.
// Ports: i_clk, i_rst_n, i_start, i_key, i_block in; o_valid, o_block out.
module aes_128_core #(
   parameter int LATENCY = 10
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [127:0] i_key,
   input  logic [127:0] i_block,
   output logic         o_valid,
   output logic [127:0] o_block
);
   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   // Entry 0 sits in the top byte of the table.
   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      logic [10:0] base;
      base = {~b, 3'b000};
      return SBOX[base +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // SubBytes followed by ShiftRows; byte i is row i%4, column i/4.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [0:15][7:0] b;
      b = s;
      return {sub_byte(b[0]),  sub_byte(b[5]),  sub_byte(b[10]), sub_byte(b[15]),
              sub_byte(b[4]),  sub_byte(b[9]),  sub_byte(b[14]), sub_byte(b[3]),
              sub_byte(b[8]),  sub_byte(b[13]), sub_byte(b[2]),  sub_byte(b[7]),
              sub_byte(b[12]), sub_byte(b[1]),  sub_byte(b[6]),  sub_byte(b[11])};
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
   endfunction

   function automatic logic [127:0] next_rk(input logic [127:0] rk, input logic [7:0] rcon);
      logic [31:0] t, n0, n1, n2, n3;
      t  = {sub_byte(rk[23:16]), sub_byte(rk[15:8]), sub_byte(rk[7:0]), sub_byte(rk[31:24])}
           ^ {rcon, 24'h000000};
      n0 = rk[127:96] ^ t;
      n1 = rk[95:64] ^ n0;
      n2 = rk[63:32] ^ n1;
      n3 = rk[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   logic         r_busy;
   logic [7:0]   r_cnt;
   logic [127:0] r_state;
   logic [127:0] r_rk;
   logic [7:0]   r_rcon;
   logic [127:0] w_rk_next;

   assign w_rk_next = next_rk(r_rk, r_rcon);
   assign o_valid   = r_busy && (r_cnt == 8'd0);
   assign o_block   = sub_shift(r_state) ^ w_rk_next;

   // Down-counter from LATENCY-1; the nine full rounds occupy the last nine counts
   // before terminal count, so any extra latency is spent idle up front.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy  <= 1'b0;
         r_cnt   <= 8'd0;
         r_state <= '0;
         r_rk    <= '0;
         r_rcon  <= 8'h01;
      end else if (i_start && !r_busy) begin
         r_busy  <= 1'b1;
         r_cnt   <= LAT_M1;
         r_state <= i_block ^ i_key;
         r_rk    <= i_key;
         r_rcon  <= 8'h01;
      end else if (r_busy) begin
         if (r_cnt == 8'd0) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt <= 8'd9) begin
               r_state <= mix_cols(sub_shift(r_state)) ^ w_rk_next;
               r_rk    <= w_rk_next;
               r_rcon  <= xtime(r_rcon);
            end
         end
      end
   end
endmodule

// State table:
//   ST_IDLE  | waiting for i_cfg_start; no input accepted
//   ST_RUN   | accepting blocks, one in the core at a time, gated by FIFO credit
//   ST_DRAIN | last (or wrap-truncated) block accepted; finish core and empty FIFO
module aes_ctr_engine #(
   parameter int CTR_WIDTH    = 32,
   parameter int OUT_DEPTH    = 4,
   parameter int CORE_LATENCY = 10
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_cfg_start,
   input  logic [127:0] i_cfg_key,
   input  logic [127:0] i_cfg_iv,
   input  logic         i_s_valid,
   output logic         o_s_ready,
   input  logic [127:0] i_s_data,
   input  logic         i_s_last,
   output logic         o_m_valid,
   input  logic         i_m_ready,
   output logic [127:0] o_m_data,
   output logic         o_m_last,
   output logic         o_busy,
   output logic         o_ctr_wrap
);
   localparam int             AW       = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam logic [AW:0]    DEPTH_C  = (AW + 1)'(OUT_DEPTH);
   localparam logic [127:0]   CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t       r_state;
   logic [127:0] r_key;
   logic [127:0] r_ctr;
   logic [127:0] r_hold_data;
   logic         r_hold_last;
   logic         r_inflight;
   logic         r_wrap;

   logic [127:0] r_fifo_data [OUT_DEPTH];
   logic         r_fifo_last [OUT_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   logic         w_s_ready;
   logic         w_accept;
   logic         w_fifo_valid;
   logic         w_pop;
   logic         w_core_valid;
   logic [127:0] w_core_block;
   logic         w_ctr_max;
   logic [127:0] w_ctr_inc;
   logic         w_head_last;
   logic [127:0] w_head_data;

   // With nothing in the core, occupancy alone is the credit count.
   assign w_s_ready    = (r_state == ST_RUN) && !r_inflight && (r_count < DEPTH_C);
   assign w_accept     = i_s_valid && w_s_ready;
   assign w_fifo_valid = (r_count != '0);
   assign w_pop        = w_fifo_valid && i_m_ready;
   assign w_ctr_max    = ((r_ctr & CTR_MASK) == CTR_MASK);
   assign w_ctr_inc    = (r_ctr & ~CTR_MASK) | ((r_ctr + 128'd1) & CTR_MASK);
   assign w_head_data  = r_fifo_data[r_rptr];
   assign w_head_last  = r_fifo_last[r_rptr];

   assign o_s_ready  = w_s_ready;
   assign o_m_valid  = w_fifo_valid;
   assign o_m_data   = w_fifo_valid ? w_head_data : '0;
   assign o_m_last   = w_fifo_valid && w_head_last;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_ctr_wrap = r_wrap;

   aes_128_core #(.LATENCY(CORE_LATENCY)) u_core (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (w_accept),
      .i_key   (r_key),
      .i_block (r_ctr),
      .o_valid (w_core_valid),
      .o_block (w_core_block)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_key       <= '0;
         r_ctr       <= '0;
         r_hold_data <= '0;
         r_hold_last <= 1'b0;
         r_inflight  <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         if (w_accept)
            r_inflight <= 1'b1;
         else if (w_core_valid)
            r_inflight <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (i_cfg_start) begin
                  r_key   <= i_cfg_key;
                  r_ctr   <= i_cfg_iv;
                  r_wrap  <= 1'b0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_hold_data <= i_s_data;
                  r_hold_last <= i_s_last || w_ctr_max;
                  r_ctr       <= w_ctr_inc;
                  // The wrapped value is loaded but never issued: we stop here.
                  if (w_ctr_max)
                     r_wrap <= 1'b1;
                  if (i_s_last || w_ctr_max)
                     r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_pop && w_head_last)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_core_valid)
            r_wptr <= r_wptr + AW'(1);
         if (w_pop)
            r_rptr <= r_rptr + AW'(1);
         case ({w_core_valid, w_pop})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_core_valid) begin
         r_fifo_data[r_wptr] <= r_hold_data ^ w_core_block;
         r_fifo_last[r_wptr] <= r_hold_last;
      end
   end
endmodule

// File: tb/tb_aes_ctr_engine.sv
module tb_aes_ctr_engine;
   localparam int CTR_WIDTH    = 32;
   localparam int OUT_DEPTH    = 4;
   localparam int CORE_LATENCY = 10;

   localparam logic [127:0] NK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] NIV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [127:0] NP0 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] NP1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] NC0 = 128'h874d6191b620e3261bef6864990db6ce;
   localparam logic [127:0] NC1 = 128'h9806f66b7970fdff8617187bb9fffdff;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_start = 1'b0;
   logic [127:0] cfg_key = '0;
   logic [127:0] cfg_iv = '0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [127:0] s_data = '0;
   logic         s_last = 1'b0;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic [127:0] m_data;
   logic         m_last;
   logic         busy;
   logic         ctr_wrap;

   always #5 clk = ~clk;

   aes_ctr_engine #(.CTR_WIDTH(CTR_WIDTH), .OUT_DEPTH(OUT_DEPTH), .CORE_LATENCY(CORE_LATENCY)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg_start(cfg_start), .i_cfg_key(cfg_key), .i_cfg_iv(cfg_iv),
      .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data), .i_s_last(s_last),
      .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data), .o_m_last(m_last),
      .o_busy(busy), .o_ctr_wrap(ctr_wrap));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference AES: S-box derived from GF(2^8) inverse + affine map, full key
   // schedule expanded up front, state as a byte array.
   logic [7:0] sb [256];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] blk);
      logic [7:0]   st [16];
      logic [7:0]   t2 [16];
      logic [31:0]  w [44];
      logic [31:0]  tw;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tw = w[i-1];
         if (i % 4 == 0) begin
            tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tw;
      end
      for (int i = 0; i < 16; i++) st[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               t2[row+4*col] = st[row+4*((col+row)%4)];
         for (int col = 0; col < 4; col++) begin
            a0 = t2[4*col]; a1 = t2[4*col+1]; a2 = t2[4*col+2]; a3 = t2[4*col+3];
            if (r < 10) begin
               st[4*col]   = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
               st[4*col+1] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
               st[4*col+2] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
               st[4*col+3] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
            end else begin
               st[4*col] = a0; st[4*col+1] = a1; st[4*col+2] = a2; st[4*col+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   // Stream model and capture.
   logic [127:0] mkey, mctr;
   bit           mwrap;
   logic [127:0] exp_data [$];
   bit           exp_last [$];
   logic [127:0] got_data [$];
   bit           got_last [$];
   int           n_acc, n_pop;
   int           cyc = 0;
   bit           rec_acc = 1'b0;
   int           acc_cyc [$];
   bit           pv, pr, pl;
   logic [127:0] pd;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_data.delete(); exp_last.delete();
         n_acc = 0; n_pop = 0; mwrap = 1'b0; pv = 1'b0;
      end else begin
         if (n_acc - n_pop >= OUT_DEPTH) chk("credit_s_ready", s_ready, 0);
         if (!busy) chk("idle_s_ready", s_ready, 0);
         chk("ctr_wrap", ctr_wrap, mwrap);
         if (pv && !pr) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, pd);
            chk("hold_last", m_last, pl);
         end
         if (m_valid && m_ready) begin
            if (exp_data.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output actual=%h required=none", m_data);
            end else begin
               chk("m_data", m_data, exp_data.pop_front());
               chk("m_last", m_last, exp_last.pop_front());
            end
            got_data.push_back(m_data);
            got_last.push_back(m_last);
            n_pop++;
         end
         if (s_valid && s_ready) begin
            exp_data.push_back(s_data ^ aes_enc(mkey, mctr));
            exp_last.push_back(s_last || (mctr[31:0] == 32'hffffffff));
            if (mctr[31:0] == 32'hffffffff) mwrap = 1'b1;
            mctr[31:0] = mctr[31:0] + 32'd1;
            n_acc++;
            if (rec_acc) acc_cyc.push_back(cyc);
         end
         if (cfg_start && !busy) begin
            mkey = cfg_key; mctr = cfg_iv; mwrap = 1'b0;
         end
         pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_stream(input logic [127:0] key, input logic [127:0] iv);
      cfg_key = key; cfg_iv = iv; cfg_start = 1'b1;
      tick(1);
      cfg_start = 1'b0;
   endtask

   task automatic send(input logic [127:0] d, input bit last, input int bound, output bit ok);
      s_valid = 1'b1; s_data = d; s_last = last; ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int bound);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         if (!busy && !m_valid) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      chk(name, ok, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_m_last"}, m_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ctr_wrap"}, ctr_wrap, 0);
   endtask

   task automatic clear_got();
      got_data.delete(); got_last.delete();
   endtask

   task automatic nist_stream(input string tag);
      bit ok;
      clear_got();
      start_stream(NK, NIV);
      send(NP0, 1'b0, 100, ok); chk({tag, "_acc0"}, ok, 1);
      send(NP1, 1'b1, 100, ok); chk({tag, "_acc1"}, ok, 1);
      wait_idle({tag, "_idle"}, 200);
      chk({tag, "_count"}, got_data.size(), 2);
      if (got_data.size() == 2) begin
         chk({tag, "_c0"}, got_data[0], NC0);
         chk({tag, "_c1"}, got_data[1], NC1);
         chk({tag, "_last0"}, got_last[0], 0);
         chk({tag, "_last1"}, got_last[1], 1);
      end
      chk({tag, "_busy"}, busy, 0);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      bit ok, done;
      logic [127:0] rk, riv;
      int len;

      for (int v = 0; v < 256; v++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int u = 1; u < 256; u++)
            if (gm(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
         sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      chk("model_nist0", aes_enc(NK, NIV) ^ NP0, NC0);
      chk("model_nist1", aes_enc(NK, NIV + 128'd1) ^ NP1, NC1);

      // Reset values
      tick(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(2);

      // NIST vectors
      nist_stream("nist");

      // Backpressure: 40 stalled cycles with a six-block stream
      clear_got();
      m_ready = 1'b0;
      start_stream(NK, NIV);
      fork
         begin
            send(NP0, 1'b0, 300, ok); chk("bp_acc0", ok, 1);
            send(NP1, 1'b0, 300, ok); chk("bp_acc1", ok, 1);
            for (int k = 2; k < 6; k++) begin
               send(rnd128(), k == 5, 300, ok);
               chk("bp_acc", ok, 1);
            end
         end
         begin
            tick(40);
            chk("bp_valid", m_valid, 1);
            chk("bp_head", m_data, NC0);
            m_ready = 1'b1;
         end
      join
      wait_idle("bp_idle", 300);
      chk("bp_count", got_data.size(), 6);
      if (got_data.size() >= 2) begin
         chk("bp_c0", got_data[0], NC0);
         chk("bp_c1", got_data[1], NC1);
      end

      // Counter wrap
      clear_got();
      start_stream(rnd128(), {96'h0, 32'hffffffff});
      send(rnd128(), 1'b0, 100, ok); chk("wrap_acc0", ok, 1);
      send(rnd128(), 1'b0, 30, ok);  chk("wrap_no_acc1", ok, 0);
      send(rnd128(), 1'b0, 5, ok);   chk("wrap_no_acc2", ok, 0);
      wait_idle("wrap_idle", 200);
      chk("wrap_count", got_data.size(), 1);
      if (got_data.size() == 1) chk("wrap_last", got_last[0], 1);
      chk("wrap_flag", ctr_wrap, 1);
      chk("wrap_busy", busy, 0);

      // Next start clears the wrap flag; cfg_start mid-stream is ignored
      clear_got();
      start_stream(NK, NIV);
      chk("wrap_cleared", ctr_wrap, 0);
      send(NP0, 1'b0, 100, ok); chk("mid_acc0", ok, 1);
      cfg_key = rnd128(); cfg_iv = rnd128(); cfg_start = 1'b1;
      tick(1);
      cfg_start = 1'b0;
      send(NP1, 1'b1, 100, ok); chk("mid_acc1", ok, 1);
      wait_idle("mid_idle", 200);
      chk("mid_count", got_data.size(), 2);
      if (got_data.size() == 2) begin
         chk("mid_c0", got_data[0], NC0);
         chk("mid_c1", got_data[1], NC1);
      end

      // Asynchronous reset with a block in the core
      start_stream(NK, NIV);
      send(NP0, 1'b0, 100, ok); chk("rst_acc0", ok, 1);
      tick(3);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      tick(2);
      rst_n = 1'b1;
      tick(1);
      nist_stream("post_rst");

      // Throughput: 8 back-to-back blocks
      clear_got();
      acc_cyc.delete();
      riv = rnd128();
      riv[31:0] = riv[31:0] & 32'h0fffffff;
      start_stream(rnd128(), riv);
      rec_acc = 1'b1;
      for (int k = 0; k < 8; k++) begin
         send(rnd128(), k == 7, 100, ok);
         chk("tp_acc", ok, 1);
      end
      rec_acc = 1'b0;
      wait_idle("tp_idle", 200);
      chk("tp_count", got_data.size(), 8);
      chk("tp_acc_count", acc_cyc.size(), 8);
      if (acc_cyc.size() == 8)
         for (int k = 1; k < 8; k++)
            chk("tp_spacing", acc_cyc[k] - acc_cyc[k-1], CORE_LATENCY + 1);

      // Random streams with random gaps and random backpressure
      for (int st = 0; st < 3; st++) begin
         clear_got();
         rk = rnd128();
         riv = rnd128();
         riv[31:0] = riv[31:0] & 32'h0fffffff;
         len = $urandom_range(3, 10);
         start_stream(rk, riv);
         done = 1'b0;
         fork
            begin
               for (int k = 0; k < len; k++) begin
                  tick($urandom_range(0, 3));
                  send(rnd128(), k == len - 1, 400, ok);
                  chk("rnd_acc", ok, 1);
               end
               done = 1'b1;
            end
            begin
               while (!done) begin
                  m_ready = ($urandom_range(0, 2) != 0);
                  tick(1);
               end
               m_ready = 1'b1;
            end
         join
         wait_idle("rnd_idle", 400);
         chk("rnd_count", got_data.size(), len);
      end

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
